// File: rtl/blink_breathe_pwm.sv
// Breathing LED driver: ramps PWM duty up/down, one step per blink_in rising edge.
// Ports: clk, rst (sync, active-high), en, blink_in -> led, duty, phase.
`timescale 1ns/1ps
module blink_breathe_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 32,
    parameter int HOLD_EDGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                blink_in,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          phase
);

    typedef enum logic [1:0] {
        HOLD_LO   = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD_HI   = 2'd2,
        RAMP_DOWN = 2'd3
    } phase_t;

    localparam int HW = (HOLD_EDGES > 1) ? $clog2(HOLD_EDGES) : 1;

    localparam logic [PWM_BITS:0]   MAX_X     = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS-1:0] MAX_N     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(STEP);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_EDGES - 1);

    phase_t              phase_q;
    phase_t              phase_d;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [HW-1:0]       hold_q;
    logic [HW-1:0]       hold_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic                led_q;
    logic                led_d;
    logic                blink_q;
    logic                adv;
    logic [PWM_BITS:0]   sum;

    // Edges seen while disabled are dropped, not queued.
    assign adv = en & blink_in & ~blink_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= HOLD_LO;
            duty_q  <= '0;
            hold_q  <= '0;
            pwm_q   <= '0;
            led_q   <= 1'b0;
            // Reset high so a level already high at release is not an edge.
            blink_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            blink_q <= blink_in;
            led_q   <= led_d;
            if (en) begin
                pwm_q <= pwm_q + PWM_BITS'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        phase_d = phase_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        sum     = {1'b0, duty_q} + STEP_X;
        if (adv) begin
            case (phase_q)
                HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        phase_d = RAMP_UP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                RAMP_UP: begin
                    // Extra carry bit lets the saturation test see overflow.
                    if (sum >= MAX_X) begin
                        duty_d  = MAX_N;
                        phase_d = HOLD_HI;
                    end else begin
                        duty_d = sum[PWM_BITS-1:0];
                    end
                end
                HOLD_HI: begin
                    if (hold_q == HOLD_LAST) begin
                        phase_d = RAMP_DOWN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                RAMP_DOWN: begin
                    if ({1'b0, duty_q} <= STEP_X) begin
                        duty_d  = '0;
                        phase_d = HOLD_LO;
                    end else begin
                        duty_d = duty_q - STEP_N;
                    end
                end
                default: begin
                    phase_d = HOLD_LO;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        led_d = en & (pwm_q < duty_q);
    end

    assign led   = led_q;
    assign duty  = duty_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_blink_breathe_pwm.sv
// Self-checking bench for blink_breathe_pwm (defaults 8/32/2).
// Edge-driven scoreboard for duty/phase, per-cycle led model.
`timescale 1ns/1ps
module tb_blink_breathe_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       blink_in;
    logic       led;
    logic [7:0] duty;
    logic [1:0] phase;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] mcnt;

    typedef struct {
        string tag;
        int    d;
        int    p;
    } exp_t;

    exp_t sbq[$];

    blink_breathe_pwm #(
        .PWM_BITS(8),
        .STEP(32),
        .HOLD_EDGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .blink_in(blink_in),
        .led(led),
        .duty(duty),
        .phase(phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side PWM counter: cleared by rst, advances on enabled cycles.
    always @(posedge clk) begin
        if (rst)
            mcnt <= 8'd0;
        else if (en)
            mcnt <= mcnt + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: one cycle high, one cycle low.
    task automatic pulse();
        blink_in = 1'b1;
        @(negedge clk);
        blink_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic edge_exp(input string tag, input int d, input int p);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.p   = p;
        sbq.push_back(e);
        pulse();
        e = sbq.pop_front();
        chk({e.tag, "_duty"}, 32'(duty), e.d);
        chk({e.tag, "_phase"}, 32'(phase), e.p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   highs;
        int   lows;
        int   c1;
        logic [7:0] prev;

        rst      = 1'b1;
        en       = 1'b1;
        blink_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_duty", 32'(duty), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_led", 32'(led), 0);

        // Test 1: level held high after release is not an edge
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("t1_duty", 32'(duty), 0);
            chk("t1_phase", 32'(phase), 0);
            chk("t1_led", 32'(led), 0);
        end
        blink_in = 1'b0;
        @(negedge clk);

        // Test 2: full breathing cycle
        edge_exp("t2_hlo", 0, 0);
        edge_exp("t2_hlo", 0, 1);
        for (int k = 1; k <= 8; k++)
            edge_exp("t2_up", (32 * k > 255) ? 255 : 32 * k, (k == 8) ? 2 : 1);
        edge_exp("t2_hhi", 255, 2);
        edge_exp("t2_hhi", 255, 3);
        for (int k = 1; k <= 8; k++)
            edge_exp("t2_dn", (255 - 32 * k < 0) ? 0 : 255 - 32 * k,
                     (k == 8) ? 0 : 3);

        // Test 3: 50% duty waveform
        edge_exp("t3_hlo", 0, 0);
        edge_exp("t3_hlo", 0, 1);
        edge_exp("t3_up", 32, 1);
        edge_exp("t3_up", 64, 1);
        edge_exp("t3_up", 96, 1);
        edge_exp("t3_up", 128, 1);
        @(negedge clk);
        highs = 0;
        for (int i = 0; i < 512; i++) begin
            prev = mcnt - 8'd1;
            chk("t3_led", 32'(led), 32'(prev < 8'd128));
            if (led === 1'b1) highs++;
            @(negedge clk);
        end
        chk("t3_highs", highs, 256);

        // Test 4: enable low freezes sequencing and blanks led
        do_reset();
        @(negedge clk);
        edge_exp("t4_hlo", 0, 0);
        edge_exp("t4_hlo", 0, 1);
        edge_exp("t4_up", 32, 1);
        edge_exp("t4_up", 64, 1);
        edge_exp("t4_up", 96, 1);
        en = 1'b0;
        @(negedge clk);
        chk("t4_led_off", 32'(led), 0);
        for (int i = 0; i < 5; i++) begin
            edge_exp("t4_frozen", 96, 1);
            chk("t4_led_frozen", 32'(led), 0);
        end
        en = 1'b1;
        edge_exp("t4_resume", 128, 1);

        // Test 5: reset mid ramp-down
        edge_exp("t5_up", 160, 1);
        edge_exp("t5_up", 192, 1);
        edge_exp("t5_up", 224, 1);
        edge_exp("t5_up", 255, 2);
        edge_exp("t5_hhi", 255, 2);
        edge_exp("t5_hhi", 255, 3);
        edge_exp("t5_dn", 223, 3);
        edge_exp("t5_dn", 191, 3);
        edge_exp("t5_dn", 159, 3);
        do_reset();
        chk("t5_duty", 32'(duty), 0);
        chk("t5_phase", 32'(phase), 0);
        chk("t5_led", 32'(led), 0);
        @(negedge clk);
        chk("t5_duty_hold", 32'(duty), 0);

        // Test 6: blink_in toggling every cycle, then duty=MAX waveform
        edge_exp("t6_hlo", 0, 0);
        edge_exp("t6_hlo", 0, 1);
        c1 = cyc;
        for (int k = 1; k <= 8; k++)
            edge_exp("t6_up", (32 * k > 255) ? 255 : 32 * k, (k == 8) ? 2 : 1);
        chk("t6_cycles", cyc - c1, 16);
        @(negedge clk);
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            prev = mcnt - 8'd1;
            chk("t6_led", 32'(led), 32'(prev < 8'd255));
            if (led === 1'b0) lows++;
            @(negedge clk);
        end
        chk("t6_lows", lows, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
